// File: rtl/firebird7_in_gate2_tessent_tdr_extest_edt_ctrl_if.sv
// IJTAG segment port bundle between the upstream SIB and the EDT control TDR.
// Enables are level-qualified: an operation happens on a rising ijtag_tck only
// when ijtag_sel=1 and the enable is high; there is no valid/ready back-pressure.
interface firebird7_in_gate2_tessent_tdr_extest_edt_ctrl_if;
   logic ijtag_sel;
   logic ijtag_si;
   logic ijtag_ce;
   logic ijtag_se;
   logic ijtag_ue;
   logic ijtag_so;

   modport master (
      output ijtag_sel, ijtag_si, ijtag_ce, ijtag_se, ijtag_ue,
      input  ijtag_so
   );

   modport slave (
      input  ijtag_sel, ijtag_si, ijtag_ce, ijtag_se, ijtag_ue,
      output ijtag_so
   );
endinterface

// File: rtl/firebird7_in_gate2_tessent_tdr_extest_edt_ctrl.sv
// EXTEST/EDT control TDR: capture/shift/update chain, sticky status flags and a
// stretched edt_update pulse whenever the control nibble changes.
module firebird7_in_gate2_tessent_tdr_extest_edt_ctrl #(
   parameter logic [7:0]  UPD_RESET  = 8'h00,
   parameter int unsigned PULSE_BASE = 1
) (
   input  logic                                         ijtag_tck,
   input  logic                                         ijtag_reset,
   firebird7_in_gate2_tessent_tdr_extest_edt_ctrl_if.slave ijtag,
   input  logic [3:0]                                   status_in,
   output logic                                         extest_en,
   output logic                                         edt_bypass,
   output logic                                         edt_single_chain,
   output logic                                         scan_bi_en,
   output logic                                         edt_update,
   output logic [7:0]                                   o_dbg_sr
);

   logic [7:0] r_sr;
   logic [7:0] r_ur;
   logic [3:0] r_st;
   logic [3:0] r_pc;
   logic       r_pulse;

   logic       w_cap;
   logic       w_shf;
   logic       w_upd;
   logic       w_change;
   logic [3:0] w_clr;
   logic [4:0] w_len_m1;
   logic [3:0] w_pc_load;

   // Capture beats shift beats update; nothing happens while deselected.
   assign w_cap    = ijtag.ijtag_sel & ijtag.ijtag_ce;
   assign w_shf    = ijtag.ijtag_sel & ~ijtag.ijtag_ce & ijtag.ijtag_se;
   assign w_upd    = ijtag.ijtag_sel & ~ijtag.ijtag_ce & ~ijtag.ijtag_se & ijtag.ijtag_ue;
   assign w_change = w_upd & (r_sr[3:0] != r_ur[3:0]);
   assign w_clr    = {4{w_cap}};

   // Pulse length uses the incoming L, saturated so the pulse never exceeds 16.
   assign w_len_m1  = 5'(PULSE_BASE) + {1'b0, r_sr[7:4]} - 5'd1;
   assign w_pc_load = (w_len_m1 > 5'd15) ? 4'hF : w_len_m1[3:0];

   always_ff @(posedge ijtag_tck) begin
      if (ijtag_reset) begin
         r_sr    <= 8'h00;
         r_ur    <= UPD_RESET;
         r_st    <= 4'h0;
         r_pc    <= 4'h0;
         r_pulse <= 1'b0;
      end else begin
         if (w_cap) begin
            r_sr <= {r_st, r_ur[3:0]};
         end else if (w_shf) begin
            r_sr <= {ijtag.ijtag_si, r_sr[7:1]};
         end else if (w_upd) begin
            r_ur <= r_sr;
         end

         // Set wins: fresh status is OR-ed in after the capture clear.
         r_st <= (r_st & ~w_clr) | status_in;

         if (w_change) begin
            r_pc    <= w_pc_load;
            r_pulse <= 1'b1;
         end else begin
            r_pulse <= (r_pc != 4'h0);
            if (r_pc != 4'h0) begin
               r_pc <= r_pc - 4'h1;
            end
         end
      end
   end

   assign ijtag.ijtag_so   = r_sr[0];
   assign extest_en        = r_ur[0];
   assign edt_bypass       = r_ur[1];
   assign edt_single_chain = r_ur[2];
   assign scan_bi_en       = r_ur[3];
   assign edt_update       = r_pulse;
   assign o_dbg_sr         = r_sr;

endmodule
